if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined processor. Holds the program counter and issues word fetches to instruction memory over a req/ack handshake. Delivers each fetched instruction with its PC+4 to the IF/ID pipeline register. Handles hazard-unit stalls with a one-entry skid buffer, and branch/jump redirects by discarding wrong-path responses.

---
 rtl/if_fetch_unit_pkg.sv | 16 +
 rtl/if_fetch_unit_skid_buf.sv | 43 ++++
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e    : fetch controller states
//   NOP_WORD         : instruction value presented when nothing was delivered
//   DEFAULT_RESET_PC : default first fetch address after reset
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry skid buffer holding a fetched {pc_4, instr} pair while the
// pipeline is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i, entry becomes valid
//   unload_i   : entry consumed, becomes empty
//   flush_i    : discard entry (highest priority)
//   data_i     : 64-bit entry to capture
//   data_o     : stored entry
//   valid_o    : entry holds live data
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        flush_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o,
    output logic        valid_o
);

    logic [63:0] data_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and presents {pc_4, instr, valid} to the IF/ID register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall_i        : hold outputs this cycle
//   redirect_i     : restart fetch at redirect_pc_i (single-cycle pulse)
//   redirect_pc_i  : redirect target
//   imem_req_o     : fetch request
//   imem_addr_o    : fetch address
//   imem_ack_i     : response strobe, may coincide with the request
//   imem_rdata_i   : instruction word, valid with ack
//   pc_4_o         : PC + 4 of delivered instruction
//   instr_o        : delivered instruction
//   instr_valid_o  : outputs hold a live instruction
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o
);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  out_addr_q;
    logic         outstanding_q;
    logic [31:0]  pc_4_q;
    logic [31:0]  instr_q;
    logic         valid_q;

    logic         req;
    logic         handshake;
    logic [31:0]  addr;
    logic [31:0]  addr_plus4_d;
    logic [31:0]  fetch_pc_d;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_valid;
    logic [63:0]  skid_data;

    always_comb begin
        // A request already seen by memory is never withdrawn; a new one is
        // held back while the stalled outputs are live or the skid is full.
        req = ((state_q == FETCH) || (state_q == KILL)) && !skid_valid &&
              (outstanding_q || !(stall_i && valid_q));
        // In FETCH the outstanding address equals fetch_pc; only KILL
        // separates them (fetch_pc already holds the redirect target).
        addr         = outstanding_q ? out_addr_q : fetch_pc_q;
        handshake    = req && imem_ack_i;
        addr_plus4_d = addr + 32'd4;
        fetch_pc_d   = fetch_pc_q + 32'd4;
        // A word arriving under stall must not disturb the held outputs,
        // so it parks in the skid until the stall lifts.
        skid_load    = (state_q == FETCH) && !redirect_i && handshake && stall_i;
        skid_unload  = (state_q == FETCH) && !redirect_i && !stall_i && skid_valid;
        skid_flush   = redirect_i;
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .data_i   ({addr_plus4_d, imem_rdata_i}),
        .data_o   (skid_data),
        .valid_o  (skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            out_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            pc_4_q        <= '0;
            instr_q       <= NOP_WORD;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (redirect_i) begin
                        valid_q    <= 1'b0;
                        fetch_pc_q <= redirect_pc_i;
                        if (req && !imem_ack_i) begin
                            state_q       <= KILL;
                            outstanding_q <= 1'b1;
                            out_addr_q    <= addr;
                        end else begin
                            outstanding_q <= 1'b0;
                        end
                    end else if (handshake) begin
                        fetch_pc_q    <= fetch_pc_d;
                        outstanding_q <= 1'b0;
                        if (!stall_i) begin
                            instr_q <= imem_rdata_i;
                            pc_4_q  <= addr_plus4_d;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        if (req) begin
                            outstanding_q <= 1'b1;
                            out_addr_q    <= addr;
                        end
                        if (!stall_i) begin
                            if (skid_valid) begin
                                pc_4_q  <= skid_data[63:32];
                                instr_q <= skid_data[31:0];
                                valid_q <= 1'b1;
                            end else begin
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                KILL: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_i;
                    end
                    if (handshake) begin
                        state_q       <= FETCH;
                        outstanding_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = addr;
    assign pc_4_o        = pc_4_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_4_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;

    int unsigned n_asrt;
    int unsigned n_fail;
    logic [63:0] sb_q[$];
    logic        auto_mem;
    int unsigned wait_n;
    int unsigned wait_cnt;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_4_o        (pc_4_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mword(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc4, input logic [31:0] ins);
        sb_q.push_back({pc4, ins});
    endtask

    // Mid-cycle: let combinational outputs settle, drive the memory model,
    // and retire the displayed instruction if IF/ID consumes it.
    task automatic settle();
        logic [63:0] e;
        #1;
        if (auto_mem) begin
            imem_ack_i   = imem_req_o && (wait_cnt >= wait_n);
            imem_rdata_i = mword(imem_addr_o);
        end
        if (instr_valid_o && !stall_i) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_pc_4", pc_4_o, e[63:32]);
                chk("sb_instr", instr_o, e[31:0]);
            end
        end
    endtask

    task automatic tick();
        if (auto_mem) begin
            if (imem_req_o && imem_ack_i) wait_cnt = 0;
            else if (imem_req_o) wait_cnt++;
        end
        @(posedge clk);
        #1;
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        imem_ack_i = 1'b0;
        wait_cnt   = 0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_pc_4", pc_4_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("idle_no_req", 32'(imem_req_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_asrt        = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = '0;
        auto_mem      = 1'b1;
        wait_n        = 0;
        wait_cnt      = 0;

        // Zero-wait memory: one instruction per cycle
        do_reset();
        push(32'd4, mword(32'd0));
        push(32'd8, mword(32'd4));
        push(32'd12, mword(32'd8));
        for (int unsigned i = 0; i < 3; i++) begin
            settle();
            chk("t1_req", 32'(imem_req_o), 32'd1);
            chk("t1_addr", imem_addr_o, 32'(4 * i));
            if (i > 0) chk("t1_valid", 32'(instr_valid_o), 32'd1);
            tick();
        end

        // Two wait states: address stable 3 cycles, valid 1,0,0
        wait_n = 2;
        for (int unsigned k = 0; k < 2; k++) begin
            push(32'(16 + 4 * k), mword(32'(12 + 4 * k)));
            for (int unsigned c = 0; c < 3; c++) begin
                settle();
                chk("t2_addr", imem_addr_o, 32'(12 + 4 * k));
                chk("t2_valid", 32'(instr_valid_o), (c == 0) ? 32'd1 : 32'd0);
                tick();
            end
        end
        settle();
        tick();
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Stall with ack during stall: skid holds the word
        auto_mem = 1'b0;
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd0); push(32'd4, mword(32'd0));
        settle(); chk("t3_addr0", imem_addr_o, 32'd0); tick();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd4); push(32'd8, mword(32'd4));
        settle(); chk("t3_addr4", imem_addr_o, 32'd4); tick();
        settle(); chk("t3_req8", 32'(imem_req_o), 32'd1); chk("t3_addr8", imem_addr_o, 32'd8); tick();
        stall_i = 1'b1;
        settle(); chk("t3_stall_req", 32'(imem_req_o), 32'd1); chk("t3_stall_valid", 32'(instr_valid_o), 32'd0); tick();
        imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        settle(); chk("t3_ack_addr", imem_addr_o, 32'd8); tick();
        settle();
        chk("t3_skid_blocks_req", 32'(imem_req_o), 32'd0);
        chk("t3_hold_valid", 32'(instr_valid_o), 32'd0);
        chk("t3_hold_pc_4", pc_4_o, 32'd8);
        chk("t3_hold_instr", instr_o, mword(32'd4));
        tick();
        stall_i = 1'b0;
        settle(); chk("t3_unstall_req", 32'(imem_req_o), 32'd0); chk("t3_unstall_valid", 32'(instr_valid_o), 32'd0); tick();
        push(32'h0000_000C, 32'h1234_5678);
        settle();
        chk("t3_valid", 32'(instr_valid_o), 32'd1);
        chk("t3_next_req", 32'(imem_req_o), 32'd1);
        chk("t3_next_addr", imem_addr_o, 32'h0000_000C);
        tick();
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect while request outstanding: response discarded in KILL
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd0); push(32'd4, mword(32'd0));
        settle(); tick();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd4); push(32'd8, mword(32'd4));
        settle(); tick();
        settle(); chk("t4_addr8", imem_addr_o, 32'd8); tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        settle(); chk("t4_req_at_redirect", 32'(imem_req_o), 32'd1); tick();
        settle();
        chk("t4_kill_req", 32'(imem_req_o), 32'd1);
        chk("t4_kill_addr", imem_addr_o, 32'd8);
        chk("t4_kill_valid", 32'(instr_valid_o), 32'd0);
        tick();
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        settle(); chk("t4_kill_ack_addr", imem_addr_o, 32'd8); tick();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'h100); push(32'h104, mword(32'h100));
        settle();
        chk("t4_discard_valid", 32'(instr_valid_o), 32'd0);
        chk("t4_target_req", 32'(imem_req_o), 32'd1);
        chk("t4_target_addr", imem_addr_o, 32'h100);
        tick();
        settle(); chk("t4_target_pc_4", pc_4_o, 32'h104); tick();
        chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect coincident with ack: data dropped, no KILL
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        settle(); chk("t5_addr0", imem_addr_o, 32'd0); tick();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'h200); push(32'h204, mword(32'h200));
        settle();
        chk("t5_drop_valid", 32'(instr_valid_o), 32'd0);
        chk("t5_req", 32'(imem_req_o), 32'd1);
        chk("t5_addr", imem_addr_o, 32'h200);
        tick();
        settle(); chk("t5_valid", 32'(instr_valid_o), 32'd1); tick();
        chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect in KILL updates target; PC wraps at top of memory
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
        settle(); tick();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        settle(); chk("t6_kill_addr", imem_addr_o, 32'd0); tick();
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        settle(); chk("t6_kill_ack_addr", imem_addr_o, 32'd0); tick();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'hFFFF_FFFC); push(32'h0, mword(32'hFFFF_FFFC));
        settle();
        chk("t6_kill_valid", 32'(instr_valid_o), 32'd0);
        chk("t6_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        settle();
        chk("t6_wrap_valid", 32'(instr_valid_o), 32'd1);
        chk("t6_wrap_addr", imem_addr_o, 32'h0);
        tick();
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-request
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = mword(32'd0); push(32'd4, mword(32'd0));
        settle(); tick();
        settle();
        chk("t7_pre_req", 32'(imem_req_o), 32'd1);
        chk("t7_pre_valid", 32'(instr_valid_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_async_req", 32'(imem_req_o), 32'd0);
        chk("t7_async_valid", 32'(instr_valid_o), 32'd0);
        do_reset();
        settle();
        chk("t7_refetch_req", 32'(imem_req_o), 32'd1);
        chk("t7_refetch_addr", imem_addr_o, 32'd0);
        tick();
        chk("t7_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
